// File: rtl/cronometro_pkg.sv
// Shared types and constants for the stopwatch run/pause/clear controller.
package cronometro_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUNNING = 2'd1,
    PAUSED  = 2'd2
  } state_t;

  localparam int SEC_U_W = 4;
  localparam int SEC_D_W = 3;
  localparam int MIN_U_W = 4;
  localparam int MIN_D_W = 3;

  localparam logic [SEC_U_W-1:0] SEC_U_MAX = 4'd9;
  localparam logic [SEC_D_W-1:0] SEC_D_MAX = 3'd5;
  localparam logic [MIN_U_W-1:0] MIN_U_MAX = 4'd9;
  localparam logic [MIN_D_W-1:0] MIN_D_MAX = 3'd5;

endpackage

// File: rtl/cron_btn_edge.sv
// Button conditioner: 2-FF synchronizer followed by a rising-edge detector.
// PRESS is high for exactly one cycle per press, however long BTN is held.
module cron_btn_edge (
  input  logic CLK,
  input  logic RST_N,
  input  logic BTN,
  output logic PRESS
);

  logic r_meta, r_sync, r_prev;

  // Synchronize the raw level and keep one cycle of history for edge detection
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
      r_prev <= 1'b0;
    end else begin
      r_meta <= BTN;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign PRESS = r_sync & ~r_prev;

endmodule

// File: rtl/cronometro_ctrl.sv
// Stopwatch controller: button conditioning, IDLE/RUNNING/PAUSED FSM,
// seconds prescaler and the mm:ss BCD digit cascade.
// Optional lap freeze enabled by defining CRONOMETRO_LAP_EN.
module cronometro_ctrl
  import cronometro_pkg::*;
#(
  parameter int TICK_DIV = 50000000
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic               START_STOP,
  input  logic               CLEAR,
  output logic [SEC_U_W-1:0] SEC_U,
  output logic [SEC_D_W-1:0] SEC_D,
  output logic [MIN_U_W-1:0] MIN_U,
  output logic [MIN_D_W-1:0] MIN_D,
  output logic               RUN,
  output logic               TICK,
  output logic               CLK_OUT,
  output logic               LAP
);

  localparam int            PW      = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);

  logic w_ss, w_clr;
  state_t r_state, w_state_nxt;
  logic [PW-1:0]      r_presc;
  logic [SEC_U_W-1:0] r_sec_u;
  logic [SEC_D_W-1:0] r_sec_d;
  logic [MIN_U_W-1:0] r_min_u;
  logic [MIN_D_W-1:0] r_min_d;
  logic w_tick, w_su_max, w_sd_max, w_mu_max, w_md_max;

  cron_btn_edge u_btn_ss  (.CLK(CLK), .RST_N(RST_N), .BTN(START_STOP), .PRESS(w_ss));
  cron_btn_edge u_btn_clr (.CLK(CLK), .RST_N(RST_N), .BTN(CLEAR),      .PRESS(w_clr));

  // State register
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next state: START_STOP wins in IDLE/RUNNING, CLEAR wins in PAUSED
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (w_ss) w_state_nxt = RUNNING;
      RUNNING: if (w_ss) w_state_nxt = PAUSED;
      PAUSED: begin
        if (w_clr)     w_state_nxt = IDLE;
        else if (w_ss) w_state_nxt = RUNNING;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign RUN      = (r_state == RUNNING);
  assign w_tick   = RUN && (r_presc == PRE_MAX);
  assign w_su_max = (r_sec_u == SEC_U_MAX);
  assign w_sd_max = (r_sec_d == SEC_D_MAX);
  assign w_mu_max = (r_min_u == MIN_U_MAX);
  assign w_md_max = (r_min_d == MIN_D_MAX);
  assign TICK     = w_tick;
  assign CLK_OUT  = w_tick && w_su_max && w_sd_max && w_mu_max && w_md_max;

  // Prescaler: counts only while running, held while paused, zeroed on entering IDLE
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)                    r_presc <= '0;
    else if (w_state_nxt == IDLE)  r_presc <= '0;
    else if (w_tick)               r_presc <= '0;
    else if (RUN)                  r_presc <= r_presc + 1'b1;
  end

  // Digit cascade: each digit steps when every lower digit is at its maximum
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_sec_u <= '0;
      r_sec_d <= '0;
      r_min_u <= '0;
      r_min_d <= '0;
    end else if (w_state_nxt == IDLE) begin
      r_sec_u <= '0;
      r_sec_d <= '0;
      r_min_u <= '0;
      r_min_d <= '0;
    end else if (w_tick) begin
      r_sec_u <= w_su_max ? '0 : r_sec_u + 1'b1;
      if (w_su_max)
        r_sec_d <= w_sd_max ? '0 : r_sec_d + 1'b1;
      if (w_su_max && w_sd_max)
        r_min_u <= w_mu_max ? '0 : r_min_u + 1'b1;
      if (w_su_max && w_sd_max && w_mu_max)
        r_min_d <= w_md_max ? '0 : r_min_d + 1'b1;
    end
  end

`ifdef CRONOMETRO_LAP_EN
  logic               w_lap_tgl;
  logic               r_lap;
  logic [SEC_U_W-1:0] r_snap_su;
  logic [SEC_D_W-1:0] r_snap_sd;
  logic [MIN_U_W-1:0] r_snap_mu;
  logic [MIN_D_W-1:0] r_snap_md;

  // A START_STOP press in the same cycle takes priority over the lap toggle
  assign w_lap_tgl = RUN && w_clr && !w_ss;

  // Lap flag and snapshot; the snapshot is taken only on the 0->1 transition
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_lap     <= 1'b0;
      r_snap_su <= '0;
      r_snap_sd <= '0;
      r_snap_mu <= '0;
      r_snap_md <= '0;
    end else if (w_state_nxt != RUNNING) begin
      r_lap <= 1'b0;
    end else if (w_lap_tgl) begin
      r_lap <= ~r_lap;
      if (!r_lap) begin
        r_snap_su <= r_sec_u;
        r_snap_sd <= r_sec_d;
        r_snap_mu <= r_min_u;
        r_snap_md <= r_min_d;
      end
    end
  end

  assign LAP   = r_lap;
  assign SEC_U = r_lap ? r_snap_su : r_sec_u;
  assign SEC_D = r_lap ? r_snap_sd : r_sec_d;
  assign MIN_U = r_lap ? r_snap_mu : r_min_u;
  assign MIN_D = r_lap ? r_snap_md : r_min_d;
`else
  assign LAP   = 1'b0;
  assign SEC_U = r_sec_u;
  assign SEC_D = r_sec_d;
  assign MIN_U = r_min_u;
  assign MIN_D = r_min_d;
`endif

endmodule

// File: tb/tb_cronometro_ctrl.sv
// Directed bench for cronometro_ctrl with TICK_DIV=4: a timed vector table
// for the counting cascade plus hand sequences for pause/clear/lap corners.
module tb_cronometro_ctrl;

`ifdef CRONOMETRO_LAP_EN
  localparam bit LAP_ON = 1'b1;
`else
  localparam bit LAP_ON = 1'b0;
`endif

  logic CLK = 1'b0;
  logic RST_N = 1'b0;
  logic START_STOP = 1'b0;
  logic CLEAR = 1'b0;
  logic [3:0] SEC_U;
  logic [2:0] SEC_D;
  logic [3:0] MIN_U;
  logic [2:0] MIN_D;
  logic RUN, TICK, CLK_OUT, LAP;

  int n_chk = 0;
  int n_pass = 0;

  cronometro_ctrl #(.TICK_DIV(4)) dut (
    .CLK(CLK), .RST_N(RST_N), .START_STOP(START_STOP), .CLEAR(CLEAR),
    .SEC_U(SEC_U), .SEC_D(SEC_D), .MIN_U(MIN_U), .MIN_D(MIN_D),
    .RUN(RUN), .TICK(TICK), .CLK_OUT(CLK_OUT), .LAP(LAP)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int t;      // cycles after the edge that entered RUNNING
    int su, sd, mu, md;
    int tick, co;
  } vec_t;

  vec_t tbl[13];

  task automatic chk(input string nm, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, got, exp);
  endtask

  task automatic chk_disp(input string nm, input int su, input int sd, input int mu, input int md);
    chk({nm, ".su"}, int'(SEC_U), su);
    chk({nm, ".sd"}, int'(SEC_D), sd);
    chk({nm, ".mu"}, int'(MIN_U), mu);
    chk({nm, ".md"}, int'(MIN_D), md);
  endtask

  // Raised after edge P0, sampled at P1, press pulse P2..P3, state moves at P3.
  // Returns 1 time unit after P3.
  task automatic press(input logic ss, input logic cl);
    @(posedge CLK); #1; START_STOP = ss; CLEAR = cl;
    @(posedge CLK); #1; START_STOP = 1'b0; CLEAR = 1'b0;
    @(posedge CLK);
    @(posedge CLK); #1;
  endtask

  task automatic do_reset();
    @(posedge CLK); #1; RST_N = 1'b0;
    START_STOP = 1'b0; CLEAR = 1'b0;
    repeat (3) @(posedge CLK);
    #1 RST_N = 1'b1;
  endtask

  initial begin
    tbl[0]  = '{1,     0,0,0,0, 0,0};
    tbl[1]  = '{3,     0,0,0,0, 1,0};
    tbl[2]  = '{4,     1,0,0,0, 0,0};
    tbl[3]  = '{36,    9,0,0,0, 0,0};
    tbl[4]  = '{39,    9,0,0,0, 1,0};
    tbl[5]  = '{40,    0,1,0,0, 0,0};
    tbl[6]  = '{240,   0,0,1,0, 0,0};
    tbl[7]  = '{2400,  0,0,0,1, 0,0};
    tbl[8]  = '{14396, 9,5,9,5, 0,0};
    tbl[9]  = '{14399, 9,5,9,5, 1,1};
    tbl[10] = '{14400, 0,0,0,0, 0,0};
    tbl[11] = '{14401, 0,0,0,0, 0,0};
    tbl[12] = '{14404, 1,0,0,0, 0,0};

    // Reset state
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk_disp("rst", 0, 0, 0, 0);
    chk("rst.run", int'(RUN), 0);
    chk("rst.tick", int'(TICK), 0);
    chk("rst.clk_out", int'(CLK_OUT), 0);
    chk("rst.lap", int'(LAP), 0);
    @(posedge CLK); #1 RST_N = 1'b1;

    // Scenario 1: single-cycle START_STOP, RUN two edges after sampling
    @(posedge CLK); #1 START_STOP = 1'b1;
    @(posedge CLK); #1 START_STOP = 1'b0;
    @(negedge CLK); chk("s1.run_p1", int'(RUN), 0);
    @(posedge CLK);
    @(negedge CLK); chk("s1.run_p2", int'(RUN), 0);
    @(posedge CLK);
    @(negedge CLK); chk("s1.run_p3", int'(RUN), 1);

    // Scenarios 1-2: counting cascade and 59:59 wrap, driven from the table
    begin
      int now_t = 0;
      for (int i = 0; i < 13; i++) begin
        repeat (tbl[i].t - now_t) @(posedge CLK);
        now_t = tbl[i].t;
        @(negedge CLK);
        chk_disp($sformatf("tbl%0d", i), tbl[i].su, tbl[i].sd, tbl[i].mu, tbl[i].md);
        chk($sformatf("tbl%0d.tick", i), int'(TICK), tbl[i].tick);
        chk($sformatf("tbl%0d.clk_out", i), int'(CLK_OUT), tbl[i].co);
      end
    end

    // Scenario 3: pause with prescaler held at 2, resume gives TICK 2 cycles later
    do_reset();
    press(1'b1, 1'b0);          // RUNNING from edge S
    repeat (34) @(posedge CLK);
    press(1'b1, 1'b0);          // PAUSED at S+38: count 9, prescaler 2
    @(negedge CLK);
    chk("s3.run", int'(RUN), 0);
    chk_disp("s3.pause", 9, 0, 0, 0);
    begin
      int bad = 0;
      for (int i = 0; i < 20; i++) begin
        @(negedge CLK);
        if (SEC_U != 4'd9 || SEC_D != 3'd0 || TICK != 1'b0) bad++;
      end
      chk("s3.frozen_cycles_bad", bad, 0);
    end
    press(1'b1, 1'b0);          // RUNNING again at edge R
    @(negedge CLK);
    chk("s3.r0.tick", int'(TICK), 0);
    @(posedge CLK); @(negedge CLK);
    chk("s3.r1.tick", int'(TICK), 1);
    chk("s3.r1.su", int'(SEC_U), 9);
    @(posedge CLK); @(negedge CLK);
    chk("s3.r2.tick", int'(TICK), 0);
    chk_disp("s3.r2", 0, 1, 0, 0);

    // Scenario 4: CLEAR in PAUSED at 00:37, then CLEAR in IDLE is ignored
    do_reset();
    press(1'b1, 1'b0);
    repeat (144) @(posedge CLK);
    press(1'b1, 1'b0);          // PAUSED at S+148
    @(negedge CLK);
    chk_disp("s4.pause", 7, 3, 0, 0);
    press(1'b0, 1'b1);
    @(negedge CLK);
    chk_disp("s4.clr", 0, 0, 0, 0);
    chk("s4.clr.run", int'(RUN), 0);
    press(1'b0, 1'b1);
    @(negedge CLK);
    chk_disp("s4.idle_clr", 0, 0, 0, 0);
    chk("s4.idle_clr.run", int'(RUN), 0);
    // Prescaler must have been zeroed: first TICK in cycle S+3
    press(1'b1, 1'b0);
    repeat (2) @(posedge CLK);
    @(negedge CLK); chk("s4.s2.tick", int'(TICK), 0);
    @(posedge CLK);
    @(negedge CLK); chk("s4.s3.tick", int'(TICK), 1);

    // Scenario 5: simultaneous presses in each state
    press(1'b1, 1'b0);          // PAUSED at S+7 with count 1
    @(negedge CLK);
    chk("s5.pause.su", int'(SEC_U), 1);
    press(1'b1, 1'b1);          // PAUSED: CLEAR wins
    @(negedge CLK);
    chk("s5.both_paused.run", int'(RUN), 0);
    chk("s5.both_paused.su", int'(SEC_U), 0);
    press(1'b1, 1'b1);          // IDLE: START_STOP wins
    @(negedge CLK);
    chk("s5.both_idle.run", int'(RUN), 1);
    press(1'b1, 1'b1);          // RUNNING: START_STOP wins, lap discarded
    @(negedge CLK);
    chk("s5.both_run.run", int'(RUN), 0);
    chk("s5.both_run.lap", int'(LAP), 0);
    press(1'b1, 1'b0);          // PAUSED -> RUNNING, still no lap
    @(negedge CLK);
    chk("s5.resume.run", int'(RUN), 1);
    chk("s5.resume.lap", int'(LAP), 0);

    // Asynchronous reset mid-run clears outputs without waiting for an edge
    repeat (9) @(posedge CLK);
    #1 RST_N = 1'b0;
    #1;
    chk("arst.run", int'(RUN), 0);
    chk_disp("arst", 0, 0, 0, 0);
    repeat (2) @(posedge CLK);
    #1 RST_N = 1'b1;

    // Button held through reset release counts as exactly one press
    @(posedge CLK); #1 RST_N = 1'b0; START_STOP = 1'b1;
    repeat (3) @(posedge CLK);
    #1 RST_N = 1'b1;
    repeat (10) @(posedge CLK);
    @(negedge CLK); chk("held.run", int'(RUN), 1);
    START_STOP = 1'b0;
    repeat (5) @(posedge CLK);
    @(negedge CLK); chk("held.run_after", int'(RUN), 1);

    // Scenario 6: lap freeze at 00:05 (or live display without the feature)
    do_reset();
    press(1'b1, 1'b0);          // RUNNING at S
    repeat (17) @(posedge CLK);
    press(1'b0, 1'b1);          // lap press takes effect at S+21
    @(negedge CLK);
    chk("s6.lap_on", int'(LAP), LAP_ON ? 1 : 0);
    chk_disp("s6.lap_on", 5, 0, 0, 0);
    repeat (8) @(posedge CLK);  // edge S+29: live count is 7
    @(negedge CLK);
    chk("s6.hold.lap", int'(LAP), LAP_ON ? 1 : 0);
    chk_disp("s6.hold", LAP_ON ? 5 : 7, 0, 0, 0);
    press(1'b0, 1'b1);          // release takes effect at S+33: live count 8
    @(negedge CLK);
    chk("s6.release.lap", int'(LAP), 0);
    chk_disp("s6.release", 8, 0, 0, 0);
    chk("s6.release.run", int'(RUN), 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
